// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3) with a
// start/busy/done handshake. It feeds the digit codes of the seg7 driver.
// Optional feature macro: BCD_OVF_DASH_EN. When it is defined, results above
// 99 show 8'hAA in the two low nibbles, so the display shows dash-dash.
module bin2bcd_seq #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + DATA_W;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    // Smallest power of ten with DIGITS zeros; used to size-check DIGITS.
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam longint unsigned BCD_CAP = pow10(DIGITS);
    localparam longint unsigned BIN_MAX = (64'd1 << DATA_W) - 64'd1;

    // Elaboration-time parameter sanity checks.
    if (DATA_W < 4 || DATA_W > 13) begin : g_bad_data_w
        $error("bin2bcd_seq: DATA_W=%0d outside legal range 4..13", DATA_W);
    end
    if (BCD_CAP <= BIN_MAX) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS=%0d too small for DATA_W=%0d", DIGITS, DATA_W);
    end

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [SR_W-1:0]       sr_q, sr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [SR_W-1:0]       sr_adj_c;
    logic [SR_W-1:0]       sr_shift_c;
    logic [BCD_W-1:0]      bcd_fin_c;
    logic                  ovf_fin_c;

    // Add-3 correction of every BCD nibble >= 5 on the registered value, then shift.
    always_comb begin
        sr_adj_c = sr_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (sr_q[DATA_W + 4*k +: 4] >= 4'd5) begin
                sr_adj_c[DATA_W + 4*k +: 4] = sr_q[DATA_W + 4*k +: 4] + 4'd3;
            end
        end
        sr_shift_c = {sr_adj_c[SR_W-2:0], 1'b0};
    end

    // Final result as it would be written on the last shift, plus overflow flag.
    always_comb begin
        bcd_fin_c = sr_shift_c[SR_W-1 -: BCD_W];
        ovf_fin_c = 1'b0;
        for (int k = 2; k < int'(DIGITS); k++) begin
            ovf_fin_c = ovf_fin_c | (|bcd_fin_c[4*k +: 4]);
        end
`ifdef BCD_OVF_DASH_EN
        if (ovf_fin_c) begin
            bcd_fin_c[7:0] = 8'hAA;
        end
`else
        bcd_fin_c = bcd_fin_c;
`endif
    end

    // Next-state and next-output logic for the IDLE/CONV controller.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = {{BCD_W{1'b0}}, bin_in};
                    cnt_d   = CNT_W'(DATA_W);
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                sr_d  = sr_shift_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = bcd_fin_c;
                    ovf_d   = ovf_fin_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
